// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-port 64 KiB memory between the CPU (port 0)
// and a secondary master (port 1), with memory-mapped UART transmit and halt
// registers decoded on the write path.
//
// Ports:
//   clock, reset_n            : clock, asynchronous active-low reset
//   pN_req/addr/we/wdata      : requester N transaction (held until pN_ack)
//   pN_ack, pN_rdata          : one-cycle completion pulse, read data (held)
//   mem_address/write_en/data_in, mem_data_out : memory port (combinational read)
//   uart_valid/data, uart_ready : UART transmit handshake
//   halted                    : sticky halt indication
module mem_bus_arbiter (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        p0_req,
  input  logic [15:0] p0_addr,
  input  logic        p0_we,
  input  logic [7:0]  p0_wdata,
  input  logic        p1_req,
  input  logic [15:0] p1_addr,
  input  logic        p1_we,
  input  logic [7:0]  p1_wdata,
  output logic        p0_ack,
  output logic [7:0]  p0_rdata,
  output logic        p1_ack,
  output logic [7:0]  p1_rdata,
  output logic [15:0] mem_address,
  output logic        mem_write_en,
  output logic [7:0]  mem_data_in,
  input  logic [7:0]  mem_data_out,
  output logic        uart_valid,
  output logic [7:0]  uart_data,
  input  logic        uart_ready,
  output logic        halted
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;

  localparam logic [AW-1:0] UART_ADDR = 16'h5a00;
  localparam logic [AW-1:0] HALT_ADDR = 16'h5b00;
  localparam logic [DW-1:0] HALT_CODE = 8'h5a;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ACCESS    = 2'd1;
  localparam logic [1:0] ST_UART_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE      = 2'd3;

  // Request payload as seen by the arbiter
  typedef struct packed {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
  } req_t;

  logic [1:0]    state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_grant_q, last_grant_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] p0_rdata_q, p0_rdata_d;
  logic [DW-1:0] p1_rdata_q, p1_rdata_d;
  logic          p0_ack_q, p0_ack_d;
  logic          p1_ack_q, p1_ack_d;
  logic          uart_valid_q, uart_valid_d;
  logic [DW-1:0] uart_data_q, uart_data_d;
  logic          halted_q, halted_d;

  req_t p0_pl_c, p1_pl_c, sel_pl_c;
  logic grant_c;

  assign p0_pl_c = '{addr: p0_addr, we: p0_we, wdata: p0_wdata};
  assign p1_pl_c = '{addr: p1_addr, we: p1_we, wdata: p1_wdata};

  // Round-robin on a tie, otherwise the lone requester wins
  always_comb begin
    grant_c = 1'b0;
    if (p0_req && p1_req) begin
      grant_c = ~last_grant_q;
    end else if (p1_req) begin
      grant_c = 1'b1;
    end
    sel_pl_c = grant_c ? p1_pl_c : p0_pl_c;
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
      p0_ack_q     <= 1'b0;
      p1_ack_q     <= 1'b0;
      uart_valid_q <= 1'b0;
      uart_data_q  <= '0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
      p0_ack_q     <= p0_ack_d;
      p1_ack_q     <= p1_ack_d;
      uart_valid_q <= uart_valid_d;
      uart_data_q  <= uart_data_d;
      halted_q     <= halted_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    p0_rdata_d   = p0_rdata_q;
    p1_rdata_d   = p1_rdata_q;
    uart_valid_d = uart_valid_q;
    uart_data_d  = uart_data_q;
    halted_d     = halted_q;

    case (state_q)
      ST_IDLE: begin
        // Halt blocks new grants; the in-flight transaction already finished
        if (!halted_q && (p0_req || p1_req)) begin
          owner_d      = grant_c;
          last_grant_d = grant_c;
          addr_d       = sel_pl_c.addr;
          we_d         = sel_pl_c.we;
          wdata_d      = sel_pl_c.wdata;
          state_d      = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!we_q) begin
          if (owner_q) begin
            p1_rdata_d = mem_data_out;
          end else begin
            p0_rdata_d = mem_data_out;
          end
          state_d = ST_DONE;
        end else if (addr_q == UART_ADDR) begin
          // RAM copy is written this cycle too; byte then waits for the UART
          uart_data_d  = wdata_q;
          uart_valid_d = 1'b1;
          state_d      = ST_UART_WAIT;
        end else begin
          if ((addr_q == HALT_ADDR) && (wdata_q == HALT_CODE)) begin
            halted_d = 1'b1;
          end
          state_d = ST_DONE;
        end
      end
      ST_UART_WAIT: begin
        if (uart_ready) begin
          uart_valid_d = 1'b0;
          state_d      = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Ack registered so it is high exactly while the state is DONE
    p0_ack_d = (state_d == ST_DONE) && !owner_d;
    p1_ack_d = (state_d == ST_DONE) &&  owner_d;
  end

  // Memory writes on the edge that closes ACCESS
  assign mem_write_en = (state_q == ST_ACCESS) && we_q;

  assign mem_address = addr_q;
  assign mem_data_in = wdata_q;
  assign p0_ack      = p0_ack_q;
  assign p1_ack      = p1_ack_q;
  assign p0_rdata    = p0_rdata_q;
  assign p1_rdata    = p1_rdata_q;
  assign uart_valid  = uart_valid_q;
  assign uart_data   = uart_data_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a behavioural 64 KiB memory.
module tb_mem_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        p0_req = 1'b0, p1_req = 1'b0;
  logic [15:0] p0_addr = '0, p1_addr = '0;
  logic        p0_we = 1'b0, p1_we = 1'b0;
  logic [7:0]  p0_wdata = '0, p1_wdata = '0;
  logic        p0_ack, p1_ack;
  logic [7:0]  p0_rdata, p1_rdata;
  logic [15:0] mem_address;
  logic        mem_write_en;
  logic [7:0]  mem_data_in, mem_data_out;
  logic        uart_valid;
  logic [7:0]  uart_data;
  logic        uart_ready = 1'b0;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;
  int we_cnt   = 0;

  logic [7:0] ram [0:65535];

  always #5 clock = ~clock;

  mem_bus_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_we(p0_we), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_we(p1_we), .p1_wdata(p1_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .mem_address(mem_address), .mem_write_en(mem_write_en),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .uart_valid(uart_valid), .uart_data(uart_data), .uart_ready(uart_ready),
    .halted(halted)
  );

  // Memory model: synchronous write, combinational read
  always @(posedge clock) if (mem_write_en) ram[mem_address] <= mem_data_in;
  assign mem_data_out = ram[mem_address];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Bus-wide invariants
  always @(negedge clock) begin
    if (reset_n) begin
      chk("single_ack", 32'(p0_ack & p1_ack), 32'd0);
      if (mem_write_en) we_cnt++;
    end
  end

  task automatic set_req(input bit port, input logic req, input logic we,
                         input logic [15:0] addr, input logic [7:0] wd);
    if (port) begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wd;
    end else begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wd;
    end
  endtask

  // Issue one transaction; lat = edges from req sample to ack (-1 on timeout)
  task automatic do_txn(input bit port, input logic we, input logic [15:0] addr,
                        input logic [7:0] wd, output int lat, output logic [7:0] rd);
    lat = -1;
    rd  = '0;
    set_req(port, 1'b1, we, addr, wd);
    for (int c = 1; c <= 20; c++) begin
      @(posedge clock); #1;
      if (port ? p1_ack : p0_ack) begin
        lat = c;
        rd  = port ? p1_rdata : p0_rdata;
        break;
      end
    end
    set_req(port, 1'b0, 1'b0, 16'h0000, 8'h00);
    @(posedge clock); #1;
    chk("ack_pulse_width", 32'(p0_ack | p1_ack), 32'd0);
  endtask

  typedef struct {
    bit          port;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int lat;
    int w0;
    logic [7:0] rd;

    for (int a = 0; a < 65536; a++) ram[a] = 8'h00;
    ram[16'hff02] = 8'h80;

    vecs[0] = '{1'b0, 1'b0, 16'hff02, 8'h00, 8'h80, 2};
    vecs[1] = '{1'b1, 1'b1, 16'h1234, 8'ha5, 8'h00, 2};
    vecs[2] = '{1'b1, 1'b0, 16'h1234, 8'h00, 8'ha5, 2};
    vecs[3] = '{1'b0, 1'b1, 16'hffff, 8'h3c, 8'h00, 2};
    vecs[4] = '{1'b1, 1'b0, 16'hffff, 8'h00, 8'h3c, 2};
    vecs[5] = '{1'b0, 1'b1, 16'h5b00, 8'h11, 8'h00, 2};
    vecs[6] = '{1'b1, 1'b0, 16'h5b00, 8'h00, 8'h11, 2};
    vecs[7] = '{1'b0, 1'b0, 16'h1000, 8'h00, 8'h01, 2};
    vecs[8] = '{1'b1, 1'b0, 16'h2000, 8'h00, 8'h02, 2};

    // Reset held with both ports requesting: no grant, all outputs zero
    set_req(1'b0, 1'b1, 1'b1, 16'h1000, 8'h01);
    set_req(1'b1, 1'b1, 1'b1, 16'h2000, 8'h02);
    repeat (3) @(posedge clock);
    #1;
    chk("rst_p0_ack", 32'(p0_ack), 32'd0);
    chk("rst_p1_ack", 32'(p1_ack), 32'd0);
    chk("rst_mem_we", 32'(mem_write_en), 32'd0);
    chk("rst_uart_valid", 32'(uart_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_p0_rdata", 32'(p0_rdata), 32'd0);
    chk("rst_p1_rdata", 32'(p1_rdata), 32'd0);
    chk("rst_mem_addr", 32'(mem_address), 32'd0);
    chk("rst_mem_din", 32'(mem_data_in), 32'd0);
    chk("rst_uart_data", 32'(uart_data), 32'd0);

    // Contention: p0 first, then strict alternation, one ack every 3 cycles
    reset_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clock); #1;
      chk($sformatf("cont_p0_ack[%0d]", i), 32'(p0_ack), 32'((i % 6) == 1));
      chk($sformatf("cont_p1_ack[%0d]", i), 32'(p1_ack), 32'((i % 6) == 4));
      chk($sformatf("cont_we[%0d]", i), 32'(mem_write_en), 32'((i % 3) == 0));
    end
    set_req(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    set_req(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
    @(posedge clock); #1;
    chk("cont_ram_1000", 32'(ram[16'h1000]), 32'h01);
    chk("cont_ram_2000", 32'(ram[16'h2000]), 32'h02);

    // Table of single-port transactions
    for (int v = 0; v < 9; v++) begin
      w0 = we_cnt;
      do_txn(vecs[v].port, vecs[v].we, vecs[v].addr, vecs[v].wdata, lat, rd);
      chk($sformatf("vec%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
      chk($sformatf("vec%0d_we_pulses", v), 32'(we_cnt - w0), 32'(vecs[v].we ? 1 : 0));
      if (vecs[v].we)
        chk($sformatf("vec%0d_ram", v), 32'(ram[vecs[v].addr]), 32'(vecs[v].wdata));
      else
        chk($sformatf("vec%0d_rdata", v), 32'(rd), 32'(vecs[v].exp_rdata));
      chk($sformatf("vec%0d_halted", v), 32'(halted), 32'd0);
    end

    // UART backpressure: byte held while uart_ready is low
    w0 = we_cnt;
    uart_ready = 1'b0;
    set_req(1'b0, 1'b1, 1'b1, 16'h5a00, 8'h48);
    @(posedge clock); #1;
    chk("uart_valid_in_access", 32'(uart_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      chk($sformatf("uart_valid_hold[%0d]", i), 32'(uart_valid), 32'd1);
      chk($sformatf("uart_data_hold[%0d]", i), 32'(uart_data), 32'h48);
      chk($sformatf("uart_no_ack[%0d]", i), 32'(p0_ack), 32'd0);
    end
    uart_ready = 1'b1;
    @(posedge clock); #1;
    chk("uart_ack", 32'(p0_ack), 32'd1);
    chk("uart_valid_cleared", 32'(uart_valid), 32'd0);
    set_req(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    uart_ready = 1'b0;
    @(posedge clock); #1;
    chk("uart_ack_width", 32'(p0_ack), 32'd0);
    chk("uart_ram", 32'(ram[16'h5a00]), 32'h48);
    chk("uart_we_pulses", 32'(we_cnt - w0), 32'd1);

    // Reset while waiting on the UART
    set_req(1'b1, 1'b1, 1'b1, 16'h5a00, 8'h55);
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("rstw_uart_valid_before", 32'(uart_valid), 32'd1);
    @(posedge clock); #3;
    reset_n = 1'b0;
    set_req(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
    #1;
    chk("rstw_uart_valid_async", 32'(uart_valid), 32'd0);
    chk("rstw_no_ack", 32'(p1_ack), 32'd0);
    #10;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      chk($sformatf("rstw_idle_ack[%0d]", i), 32'(p0_ack | p1_ack), 32'd0);
      chk($sformatf("rstw_idle_uart[%0d]", i), 32'(uart_valid), 32'd0);
    end
    chk("rstw_ram_kept", 32'(ram[16'h5a00]), 32'h55);
    do_txn(1'b0, 1'b0, 16'h5a00, 8'h00, lat, rd);
    chk("rstw_after_latency", 32'(lat), 32'd2);
    chk("rstw_after_rdata", 32'(rd), 32'h55);

    // Halt: p1 writes the halt code, afterwards nothing is granted
    do_txn(1'b1, 1'b1, 16'h5b00, 8'h5a, lat, rd);
    chk("halt_latency", 32'(lat), 32'd2);
    chk("halt_set", 32'(halted), 32'd1);
    chk("halt_ram", 32'(ram[16'h5b00]), 32'h5a);
    w0 = we_cnt;
    set_req(1'b0, 1'b1, 1'b1, 16'h3000, 8'h99);
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      chk($sformatf("halt_no_ack[%0d]", i), 32'(p0_ack), 32'd0);
    end
    chk("halt_no_write", 32'(we_cnt - w0), 32'd0);
    chk("halt_sticky", 32'(halted), 32'd1);
    set_req(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
